// File: rtl/exec_writeback_sequencer.sv
// Write-back sequencer: retires execute results through the single register-file
// write port, serialising dual-result multiplies over two cycles and updating NZCV.
module exec_writeback_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int PC_ADDR = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              cond_pass,
    input  logic              we1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] res1,
    input  logic [DATA_W-1:0] res2,
    input  logic              flag_we,
    input  logic [3:0]        cond_flags,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic [3:0]        nzcv,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_ADDR);

    typedef enum logic [1:0] {IDLE, ONE, FIRST, SECOND} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wa2_q;
    logic [DATA_W-1:0]   res2_q;
    logic                rf_we_q, pc_we_q, busy_q;
    logic [ADDR_W-1:0]   rf_wa_q;
    logic [DATA_W-1:0]   rf_wd_q, pc_wd_q;
    logic [3:0]          nzcv_q;

    logic                xfer, dual;
    logic                slot_en;
    logic [ADDR_W-1:0]   slot_wa;
    logic [DATA_W-1:0]   slot_wd;

    assign ready_in = (state_q != FIRST);
    assign xfer     = valid_in && ready_in;
    assign dual     = cond_pass && we1 && we2;

    // Choose what the write slot of the next cycle carries; the held second
    // result always wins while a dual is half-retired.
    always_comb begin
        state_d = IDLE;
        slot_en = 1'b0;
        slot_wa = wa1;
        slot_wd = res1;
        if (state_q == FIRST) begin
            state_d = SECOND;
            slot_en = 1'b1;
            slot_wa = wa2_q;
            slot_wd = res2_q;
        end else if (xfer) begin
            state_d = dual ? FIRST : ONE;
            if (cond_pass) begin
                if (we1) begin
                    slot_en = 1'b1;
                end else if (we2) begin
                    slot_en = 1'b1;
                    slot_wa = wa2;
                    slot_wd = res2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wa2_q   <= '0;
            res2_q  <= '0;
            rf_we_q <= 1'b0;
            pc_we_q <= 1'b0;
            busy_q  <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            pc_wd_q <= '0;
            nzcv_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == FIRST);
            rf_we_q <= slot_en && (slot_wa != PC_IDX);
            pc_we_q <= slot_en && (slot_wa == PC_IDX);
            if (slot_en) begin
                rf_wa_q <= slot_wa;
                rf_wd_q <= slot_wd;
            end
            if (slot_en && (slot_wa == PC_IDX)) begin
                pc_wd_q <= slot_wd;
            end
            // Second payload is frozen here so execute may move on during FIRST.
            if (xfer && dual) begin
                wa2_q  <= wa2;
                res2_q <= res2;
            end
            if (xfer && cond_pass && flag_we) begin
                nzcv_q <= cond_flags;
            end
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;
    assign pc_we = pc_we_q;
    assign pc_wd = pc_wd_q;
    assign nzcv  = nzcv_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_exec_writeback_sequencer.sv
// Bench for exec_writeback_sequencer: directed scenarios plus a randomized run
// checked against a queue-of-write-slots reference model.
module tb_exec_writeback_sequencer;

    logic        clk, reset_n, valid_in, ready_in, cond_pass, we1, we2, flag_we;
    logic [3:0]  wa1, wa2, cond_flags, rf_wa, nzcv;
    logic [31:0] res1, res2, rf_wd, pc_wd;
    logic        rf_we, pc_we, busy;

    exec_writeback_sequencer #(.DATA_W(32), .ADDR_W(4), .PC_ADDR(15)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
        .cond_pass(cond_pass), .we1(we1), .we2(we2), .wa1(wa1), .wa2(wa2),
        .res1(res1), .res2(res2), .flag_we(flag_we), .cond_flags(cond_flags),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pc_we(pc_we), .pc_wd(pc_wd),
        .nzcv(nzcv), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        logic [3:0]  addr;
        logic [31:0] data;
    } slot_t;

    // Each accepted instruction queues the write slots it will occupy; one slot
    // drains per cycle, and new work is accepted only when nothing is queued.
    slot_t       slotQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          expReadyPre, readySeen, expRfWe, expPcWe, expBusy, expReady;
    logic [3:0]  expAddr, expNzcv;
    logic [31:0] expData;

    task automatic modelReset();
        slotQ.delete();
        expNzcv = 4'b0000;
        expRfWe = 1'b0;
        expPcWe = 1'b0;
        expBusy = 1'b0;
        expReady = 1'b1;
    endtask

    task automatic applyStimulus(input bit v, input bit cp, input bit w1, input bit w2,
                                 input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input bit fw, input logic [3:0] fl);
        slot_t s;
        valid_in = v; cond_pass = cp; we1 = w1; we2 = w2; wa1 = a1; wa2 = a2;
        res1 = d1; res2 = d2; flag_we = fw; cond_flags = fl;
        #1;
        readySeen   = ready_in;
        expReadyPre = (slotQ.size() == 0);
        if (v && expReadyPre) begin
            if (!cp)            slotQ.push_back('{0, 4'd0, 32'd0});
            else if (w1 && w2) begin
                slotQ.push_back('{1, a1, d1});
                slotQ.push_back('{1, a2, d2});
            end
            else if (w1)        slotQ.push_back('{1, a1, d1});
            else if (w2)        slotQ.push_back('{1, a2, d2});
            else                slotQ.push_back('{0, 4'd0, 32'd0});
            if (cp && fw) expNzcv = fl;
        end
        @(posedge clk);
        #1;
        if (slotQ.size() > 0) s = slotQ.pop_front();
        else                  s = '{0, 4'd0, 32'd0};
        expRfWe  = s.en && (s.addr != 4'd15);
        expPcWe  = s.en && (s.addr == 4'd15);
        expAddr  = s.addr;
        expData  = s.data;
        expBusy  = (slotQ.size() != 0);
        expReady = (slotQ.size() == 0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 4'd0, 4'd0, 32'd0, 32'd0, 0, 4'd0);
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 1, 0, 4'd15, 4'd0, 32'h44, 32'd0, 1, 4'b1111);
        applyStimulus(1, 1, 1, 1, 4'd2, 4'd3, 32'hAAAA_0002, 32'hBBBB_0003, 1, 4'b1001);
        valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({rf_we, pc_we, busy, rf_wa, rf_wd, pc_wd, nzcv} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got we=%0b pcwe=%0b busy=%0b wa=%0h wd=%0h pcwd=%0h nzcv=%b, expected all 0",
                     rf_we, pc_we, busy, rf_wa, rf_wd, pc_wd, nzcv);
        end
        vectors++;
        if (ready_in !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready_in);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
        #1;
        vectors++;
        if (ready_in !== 1'b1 || nzcv !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got ready=%b nzcv=%b expected ready=1 nzcv=0000", ready_in, nzcv);
        end
    endtask

    task automatic test_single_adds();
        applyStimulus(1, 1, 1, 0, 4'd3, 4'd0, 32'h0000_0005, 32'd0, 1, 4'b0010);
        vectors++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd3 || rf_wd !== 32'd5 || pc_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL adds_write: got we=%b wa=%0d wd=%0h pcwe=%b expected we=1 wa=3 wd=5 pcwe=0", rf_we, rf_wa, rf_wd, pc_we);
        end
        vectors++;
        if (nzcv !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL adds_nzcv: got %b expected 0010", nzcv);
        end
        idle();
    endtask

    task automatic test_umull();
        applyStimulus(1, 1, 1, 1, 4'd4, 4'd5, 32'h1, 32'hFFFF_FFFE, 0, 4'd0);
        vectors++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd4 || rf_wd !== 32'h1 || ready_in !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL umull_first: got we=%b wa=%0d wd=%0h ready=%b busy=%b expected 1/4/1/0/1", rf_we, rf_wa, rf_wd, ready_in, busy);
        end
        applyStimulus(1, 1, 1, 0, 4'd6, 4'd9, 32'h66, 32'hDEAD, 0, 4'd0);
        vectors++;
        if (readySeen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL umull_stall: got ready=%b expected 0", readySeen);
        end
        vectors++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd5 || rf_wd !== 32'hFFFF_FFFE || ready_in !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL umull_second: got we=%b wa=%0d wd=%0h ready=%b busy=%b expected 1/5/fffffffe/1/0", rf_we, rf_wa, rf_wd, ready_in, busy);
        end
        applyStimulus(1, 1, 1, 0, 4'd6, 4'd9, 32'h66, 32'hDEAD, 0, 4'd0);
        vectors++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd6 || rf_wd !== 32'h66) begin
            miscompares++;
            $display("[TB] FAIL umull_next: got we=%b wa=%0d wd=%0h expected 1/6/66", rf_we, rf_wa, rf_wd);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 1, 1, 0, 4'(i), 4'd0, 32'(i * 16), 32'd0, 0, 4'd0);
            vectors++;
            if (readySeen !== 1'b1 || rf_we !== 1'b1 || rf_wa !== 4'(i) || rf_wd !== 32'(i * 16)) begin
                miscompares++;
                $display("[TB] FAIL b2b_%0d: got ready=%b we=%b wa=%0d wd=%0h expected 1/1/%0d/%0h",
                         i, readySeen, rf_we, rf_wa, rf_wd, i, i * 16);
            end
        end
        idle();
    endtask

    task automatic test_cond_fail();
        applyStimulus(1, 0, 1, 0, 4'd7, 4'd0, 32'h77, 32'd0, 1, 4'b1111);
        vectors++;
        if (rf_we !== 1'b0 || pc_we !== 1'b0 || nzcv !== 4'b0010 || ready_in !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL condfail: got we=%b pcwe=%b nzcv=%b ready=%b expected 0/0/0010/1", rf_we, pc_we, nzcv, ready_in);
        end
        applyStimulus(1, 1, 1, 0, 4'd8, 4'd0, 32'h88, 32'd0, 0, 4'd0);
        vectors++;
        if (readySeen !== 1'b1 || rf_we !== 1'b1 || rf_wa !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL condfail_next: got ready=%b we=%b wa=%0d expected 1/1/8", readySeen, rf_we, rf_wa);
        end
        idle();
    endtask

    task automatic test_pc_write();
        applyStimulus(1, 1, 1, 0, 4'd15, 4'd0, 32'h0000_0100, 32'd0, 0, 4'd0);
        vectors++;
        if (pc_we !== 1'b1 || pc_wd !== 32'h100 || rf_we !== 1'b0 || rf_wa !== 4'd15 || rf_wd !== 32'h100) begin
            miscompares++;
            $display("[TB] FAIL pc_write: got pcwe=%b pcwd=%0h we=%b wa=%0d wd=%0h expected 1/100/0/15/100", pc_we, pc_wd, rf_we, rf_wa, rf_wd);
        end
        idle();
    endtask

    task automatic test_reset_during_first();
        applyStimulus(1, 1, 1, 1, 4'd10, 4'd11, 32'hA, 32'hB, 0, 4'd0);
        valid_in = 1'b0;
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            idle();
            vectors++;
            if (rf_we !== 1'b0 || pc_we !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rst_first_%0d: got we=%b pcwe=%b busy=%b expected 0/0/0", i, rf_we, pc_we, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                          1'($urandom), 1'($urandom),
                          4'($urandom), ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom),
                          $urandom, $urandom, 1'($urandom), 4'($urandom));
            vectors++;
            if (readySeen !== expReadyPre || ready_in !== expReady || busy !== expBusy) begin
                miscompares++;
                $display("[TB] FAIL rnd_flow[%0d]: got ready_pre=%b ready=%b busy=%b expected %b/%b/%b",
                         n, readySeen, ready_in, busy, expReadyPre, expReady, expBusy);
            end
            vectors++;
            if (rf_we !== expRfWe || pc_we !== expPcWe || nzcv !== expNzcv) begin
                miscompares++;
                $display("[TB] FAIL rnd_ctl[%0d]: got we=%b pcwe=%b nzcv=%b expected %b/%b/%b",
                         n, rf_we, pc_we, nzcv, expRfWe, expPcWe, expNzcv);
            end
            if (expRfWe || expPcWe) begin
                vectors++;
                if (rf_wa !== expAddr || rf_wd !== expData || (expPcWe && pc_wd !== expData)) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_data[%0d]: got wa=%0d wd=%0h pcwd=%0h expected wa=%0d wd=%0h",
                             n, rf_wa, rf_wd, pc_wd, expAddr, expData);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        valid_in = 0; cond_pass = 0; we1 = 0; we2 = 0; wa1 = 0; wa2 = 0;
        res1 = 0; res2 = 0; flag_we = 0; cond_flags = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_single_adds();
        test_umull();
        test_back_to_back();
        test_cond_fail();
        test_pc_write();
        test_reset_during_first();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
